// File: rtl/calc_pkg.sv
// calc_pkg: shared operator/state enums for the calc_seq sequencer.
// Build option: CALC_SEQ_DIV_EN enables the iterative divider.
package calc_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // True when the operator runs WIDTH shift/subtract steps in EXEC.
  function automatic logic is_iter(input op_t op);
`ifdef CALC_SEQ_DIV_EN
    return (op == MUL) || (op == DIV);
`else
    return (op == MUL);
`endif
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// calc_iter_unit: WIDTH-step shift-add multiplier / restoring divider.
// Build option: CALC_SEQ_DIV_EN adds the divide step.
module calc_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi, step_lo;
`ifdef CALC_SEQ_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
`endif

  // One iteration: hi:lo is the product (MUL) or remainder:quotient (DIV).
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_i} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], lo_q[WIDTH-1:1]};
`ifdef CALC_SEQ_DIV_EN
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, b_i};
    if (is_div_i) begin
      if (!rem_sub[WIDTH]) begin
        step_hi = rem_sub[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Load on start, advance one step per enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (start_i) begin
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = is_div_i ? a_i : b_i;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign done_o = step_i && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/calc_seq.sv
// calc_seq: IDLE/LOAD/EXEC/WRITE arithmetic sequencer (ADD/SUB/MUL/DIV).
// Build option: CALC_SEQ_DIV_EN; undefined makes DIV a fast error.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             err_o
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             iter_start, iter_step, iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic [WIDTH:0]   add_sum, sub_dif;

  assign iter_start = (state_q == LOAD) && is_iter(op_q);
  assign iter_step  = (state_q == EXEC) && is_iter(op_q);

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (iter_start),
    .step_i   (iter_step),
    .is_div_i (op_q == DIV),
    .a_i      (a_q),
    .b_i      (b_q),
    .done_o   (iter_done),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo)
  );

  // Next state, operand capture and WRITE-time result selection.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    done_d  = 1'b0;
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    sub_dif = {1'b0, a_q} - {1'b0, b_q};
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_t'(op_i);
          a_d     = a_i;
          b_d     = b_i;
          state_d = LOAD;
        end
      end
      LOAD: state_d = EXEC;
      EXEC: begin
        if (!is_iter(op_q) || iter_done) state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        unique case (op_q)
          ADD: {ovf_d, res_d} = add_sum;
          SUB: begin
            res_d = sub_dif[WIDTH-1:0];
            ovf_d = sub_dif[WIDTH];
          end
          MUL: begin
            res_d = iter_lo;
            ovf_d = |iter_hi;
          end
          DIV: begin
`ifdef CALC_SEQ_DIV_EN
            err_d = (b_q == '0);
            res_d = err_d ? '0 : iter_lo;
`else
            err_d = 1'b1;
            res_d = '0;
`endif
          end
        endcase
      end
    endcase
  end

  // Sequencer state, operand and result registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      op_q    <= ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = res_q;
  assign ovf_o    = ovf_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed + random ops checked against an arithmetic model.
// Honours CALC_SEQ_DIV_EN the same way as the design.
module tb_calc_seq;

  localparam int W = 8;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i    = '0;
  logic [W-1:0] a_i     = '0;
  logic [W-1:0] b_i     = '0;
  logic         busy_o, done_o, ovf_o, err_o;
  logic [W-1:0] result_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock_i = ~clock_i;

  calc_seq #(.WIDTH(W)) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .ovf_o    (ovf_o),
    .err_o    (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint res;
    longint ovf;
    longint err;
    int     lat;
  } exp_t;

  function automatic exp_t model(input int op, input longint a,
                                 input longint b);
    exp_t   e;
    longint m;
    longint full;
    m     = longint'(1) << W;
    e.res = 0;
    e.ovf = 0;
    e.err = 0;
    e.lat = 4;
    case (op)
      0: begin
        full  = a + b;
        e.res = full % m;
        e.ovf = (full >= m) ? 1 : 0;
      end
      1: begin
        e.res = (a - b + m) % m;
        e.ovf = (a < b) ? 1 : 0;
      end
      2: begin
        full  = a * b;
        e.res = full % m;
        e.ovf = (full >= m) ? 1 : 0;
        e.lat = W + 3;
      end
      default: begin
`ifdef CALC_SEQ_DIV_EN
        e.lat = W + 3;
        if (b == 0) e.err = 1;
        else e.res = a / b;
`else
        e.err = 1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic run_op(input string tag, input int op, input longint a,
                        input longint b, input bit noise);
    exp_t e;
    int   lat;
    bit   seen;
    e = model(op, a, b);
    @(negedge clock_i);
    start_i = 1'b1;
    op_i    = 2'(op);
    a_i     = W'(a);
    b_i     = W'(b);
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    lat     = 1;
    seen    = 1'b0;
    if (noise) begin
      a_i  = W'($urandom);
      b_i  = W'($urandom);
      op_i = 2'($urandom);
    end
    for (int k = 0; k < W + 10 && !seen; k++) begin
      @(negedge clock_i);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (k == 0) chk({tag, ".busy"}, busy_o, 1);
        if (noise) start_i = 1'($urandom);
        @(posedge clock_i);
        #1;
        lat++;
      end
    end
    start_i = 1'b0;
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".result"}, result_o, e.res);
    chk({tag, ".ovf"}, ovf_o, e.ovf);
    chk({tag, ".err"}, err_o, e.err);
    chk({tag, ".idle"}, busy_o, 0);
    @(negedge clock_i);
    chk({tag, ".pulse"}, done_o, 0);
  endtask

  initial begin
    exp_t e1, e2;
    int   d1, d2, edges, pulses;
    longint ra, rb;
    int   rop;

    repeat (2) @(negedge clock_i);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.result", result_o, 0);
    chk("rst.ovf", ovf_o, 0);
    chk("rst.err", err_o, 0);
    reset_i = 1'b1;

    run_op("add_200_100", 0, 200, 100, 0);
    run_op("sub_5_7", 1, 5, 7, 0);
    run_op("mul_15_17", 2, 15, 17, 0);
    run_op("div_100_7", 3, 100, 7, 0);
    run_op("div_9_0", 3, 9, 0, 0);
    run_op("add_255_1", 0, 255, 1, 0);
    run_op("sub_0_0", 1, 0, 0, 0);
    run_op("mul_255_255", 2, 255, 255, 0);
    run_op("mul_noise", 2, 13, 11, 1);

    run_op("pre_rst_add", 0, 200, 100, 0);
    @(negedge clock_i);
    start_i = 1'b1;
    op_i    = 2'd2;
    a_i     = 8'd15;
    b_i     = 8'd17;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    chk("mid_rst.busy_before", busy_o, 1);
    reset_i = 1'b0;
    #1;
    chk("mid_rst.busy", busy_o, 0);
    chk("mid_rst.result", result_o, 0);
    chk("mid_rst.done", done_o, 0);
    chk("mid_rst.ovf", ovf_o, 0);
    chk("mid_rst.err", err_o, 0);
    @(negedge clock_i);
    reset_i = 1'b1;
    pulses  = 0;
    repeat (W + 6) begin
      @(negedge clock_i);
      if (done_o) pulses++;
    end
    chk("mid_rst.no_done", pulses, 0);
    run_op("post_rst_add", 0, 1, 1, 0);

    e1 = model(2, 23, 9);
    e2 = model(2, 7, 200);
    @(negedge clock_i);
    start_i = 1'b1;
    op_i    = 2'd2;
    a_i     = 8'd23;
    b_i     = 8'd9;
    edges   = 0;
    d1      = -1;
    d2      = -1;
    for (int k = 0; k < 3 * W + 20 && d2 < 0; k++) begin
      @(posedge clock_i);
      edges++;
      @(negedge clock_i);
      if (done_o) begin
        if (d1 < 0) begin
          d1 = edges;
          chk("b2b.res1", result_o, e1.res);
          a_i = 8'd7;
          b_i = 8'd200;
        end else begin
          d2 = edges;
          start_i = 1'b0;
          chk("b2b.res2", result_o, e2.res);
          chk("b2b.ovf2", ovf_o, e2.ovf);
        end
      end
    end
    start_i = 1'b0;
    chk("b2b.first_lat", d1, e1.lat);
    chk("b2b.gap", d2 - d1, e2.lat);
    @(negedge clock_i);
    chk("b2b.stop", done_o, 0);

    for (int i = 0; i < 40; i++) begin
      rop = int'($urandom_range(0, 3));
      ra  = longint'($urandom_range(0, (1 << W) - 1));
      rb  = ($urandom_range(0, 7) == 0) ? 0 :
            longint'($urandom_range(0, (1 << W) - 1));
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clock_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  2  operator: 0=ADD, 1=SUB, 2=MUL, 3=DIV.
REQ-006 SHALL have port a_i  input  WIDTH  operand A, unsigned.
REQ-007 SHALL have port b_i  input  WIDTH  operand B, unsigned.
REQ-008 SHALL have port busy_o  output  1  high in LOAD, EXEC and WRITE.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse; result_o/ovf_o/err_o valid.
REQ-010 SHALL have port result_o  output  WIDTH  registered result, held until next done_o.
REQ-011 SHALL have port ovf_o  output  1  carry (ADD), borrow (SUB), nonzero upper half (MUL); 0 for DIV.
REQ-012 SHALL have port err_o  output  1  divide-by-zero or unsupported operator.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> EXEC -> WRITE -> IDLE.
REQ-014 IDLE with start_i=1 at an edge SHALL capture a_i, b_i, op_i into internal operand registers and go to LOAD.
REQ-015 start_i SHALL be ignored outside IDLE; the operand registers SHALL not change while busy_o=1.
REQ-016 LOAD SHALL last 1 cycle (initialise the accumulator and the iteration counter).
REQ-017 EXEC SHALL last 1 cycle for ADD/SUB and exactly WIDTH cycles for MUL (shift-add) and DIV (restoring).
REQ-018 WRITE SHALL last 1 cycle and load result_o, ovf_o and err_o.
REQ-019 done_o SHALL be 1 for exactly the cycle after WRITE (back in IDLE).
REQ-020 Latency from the start edge to done_o SHALL be 4 cycles for ADD/SUB and WIDTH+3 for MUL/DIV.
REQ-021 start_i=1 during the done_o cycle SHALL be accepted, giving back-to-back operation.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; MUL SHALL return the low WIDTH bits of the product.
REQ-023 DIV SHALL return the quotient with the remainder discarded; b=0 SHALL give result 0 and err_o=1, still taking full latency.
REQ-024 err_o, ovf_o and result_o SHALL be updated only in WRITE.

Reset
REQ-025 reset_i low SHALL immediately force IDLE and clear result_o, ovf_o, err_o, done_o, busy_o and the internal registers, including mid-operation.
REQ-026 After reset_i deasserts, no done_o SHALL be produced for an operation aborted by reset.

Configuration
REQ-027 Macro CALC_SEQ_DIV_EN defined: DIV SHALL be implemented as specified.
REQ-028 Macro CALC_SEQ_DIV_EN undefined: no divider logic; op=DIV SHALL skip EXEC iteration (latency 4), result 0, err_o=1.

Structure
REQ-029 Package calc_pkg SHALL hold the op_t enum (ADD/SUB/MUL/DIV) and the state_t enum (IDLE/LOAD/EXEC/WRITE).
REQ-030 The iterative MUL/DIV datapath SHALL be a sub-module calc_iter_unit (start, count, done); the FSM and the ADD/SUB logic SHALL stay in calc_seq.

Verification
REQ-031 WIDTH=8, ADD a=200 b=100 -> done_o 4 cycles after start, result_o=44, ovf_o=1, err_o=0.
REQ-032 SUB a=5 b=7 -> result_o=254, ovf_o=1; MUL a=15 b=17 -> result_o=255, ovf_o=0, done_o at start+11.
REQ-033 DIV a=100 b=7 -> result_o=14, err_o=0; DIV a=9 b=0 -> result_o=0, err_o=1 (CALC_SEQ_DIV_EN defined); without the macro, DIV a=100 b=7 -> err_o=1 at start+4.
REQ-034 start_i pulsed during EXEC of a MUL with different operands -> ignored, MUL result unchanged, single done_o.
REQ-035 reset_i low in EXEC cycle 3 of a MUL -> busy_o=0 and result_o=0 immediately, no done_o after release; a subsequent ADD 1+1 -> 2.
REQ-036 start_i held high across the done_o cycle -> second operation accepted, done_o pulses separated by the exact latency.
